// File: rtl/dsp_seq.sv
// dsp_seq: sequencer and result reader for one systolic DSP MAC cell.
// Optional build macro DSP_SEQ_RES_SKID_EN: a 2-entry result FIFO replaces the HOLD state.
module dsp_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  output logic [15:0]      a_value,
  output logic [15:0]      b_value,
  output logic             aen,
  output logic             ben,
  output logic             men,
  output logic             sen,
  output logic             sreset,
  input  logic             sat,
  input  logic [15:0]      s_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             v1;
  logic             l1;
  logic             v2;
  logic             l2;
  logic             accept;
  logic             last;
  logic             take;
  logic             zero_len;
  logic             fin;
  logic             pop;

  assign a_value  = a_in;
  assign b_value  = b_in;
  assign accept   = in_valid & in_ready;
  assign last     = accept & (cnt_q == len_q - LEN_W'(1));
  assign zero_len = (vec_len == '0);
  assign fin      = v2 & l2;
  assign pop      = res_valid & res_ready;

`ifdef DSP_SEQ_RES_SKID_EN
  // Results land in the FIFO, so the FSM never parks in HOLD.
  localparam state_t RESULT_STATE = IDLE;

  logic [16:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        push;
  logic [16:0] push_data;

  // Outside IDLE one result is always in flight, so only IDLE needs the room check.
  assign take      = (state == IDLE) & start & (fifo_cnt < 2'd2);
  assign push      = (take & zero_len) | ((state == DRAIN) & fin);
  assign push_data = (state == DRAIN) ? {sat, s_out} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign res_data = fifo_mem[rd_ptr][15:0];
  assign res_sat  = fifo_mem[rd_ptr][16];
`else
  localparam state_t RESULT_STATE = HOLD;

  logic [15:0] data_q;
  logic        sat_q;

  assign take = (state == IDLE) & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (take & zero_len) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if ((state == DRAIN) & fin) begin
      data_q <= s_out;
      sat_q  <= sat;
    end
  end

  assign res_data = data_q;
  assign res_sat  = sat_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take & ~zero_len) state_nx = RUN;
        else if (take)        state_nx = RESULT_STATE;
      end
      RUN:   if (last) state_nx = DRAIN;
      DRAIN: if (fin)  state_nx = RESULT_STATE;
      HOLD:  if (pop)  state_nx = IDLE;
    endcase
  end

  // The cell sees the final beat as sreset instead of sen, two cycles after its accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
      v1    <= 1'b0;
      l1    <= 1'b0;
      v2    <= 1'b0;
      l2    <= 1'b0;
    end else begin
      if (take) begin
        len_q <= vec_len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      v1 <= accept;
      l1 <= last;
      v2 <= v1;
      l2 <= l1;
    end
  end

  always_comb begin
    in_ready = (state == RUN);
    aen      = in_valid & (state == RUN);
    ben      = in_valid & (state == RUN);
    men      = v1;
    sen      = v2 & ~l2;
    sreset   = v2 & l2;
    busy     = (state != IDLE);
`ifdef DSP_SEQ_RES_SKID_EN
    res_valid = (fifo_cnt != 2'd0);
`else
    res_valid = (state == HOLD);
`endif
  end

endmodule

// File: tb/tb_dsp_seq.sv
// tb_dsp_seq: self-checking bench for dsp_seq with a behavioural MAC cell model
// and a plain-arithmetic dot-product reference.
`timescale 1ns/1ps
module tb_dsp_seq;
  localparam int LEN_W = 8;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      a_in = '0;
  logic [15:0]      b_in = '0;
  logic [15:0]      a_value;
  logic [15:0]      b_value;
  logic             aen, ben, men, sen, sreset;
  logic             sat;
  logic [15:0]      s_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [15:0]      res_data;
  logic             res_sat;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsp_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .a_value(a_value), .b_value(b_value),
    .aen(aen), .ben(ben), .men(men), .sen(sen), .sreset(sreset),
    .sat(sat), .s_out(s_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sat(res_sat), .busy(busy)
  );

  // ---------------- behavioural MAC cell ----------------
  function automatic longint clamp32(input longint x);
    if (x > MAX32) return MAX32;
    if (x < MIN32) return MIN32;
    return x;
  endfunction

  logic signed [15:0] c_a, c_b;
  int                 c_m, c_acc;
  longint             c_fin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_a <= '0; c_b <= '0; c_m <= 0; c_acc <= 0;
    end else begin
      if (aen) c_a <= a_value;
      if (ben) c_b <= b_value;
      if (men) c_m <= int'(c_a) * int'(c_b);
      if (sreset)   c_acc <= 0;
      else if (sen) c_acc <= int'(clamp32(longint'(c_acc) + longint'(c_m)));
    end
  end

  always_comb begin
    c_fin = clamp32(longint'(c_acc) + longint'(c_m));
    s_out = 16'h0000;
    sat   = 1'b0;
    if (c_fin > 64'sd32767)       begin s_out = 16'h7fff; sat = 1'b1; end
    else if (c_fin < -64'sd32768) begin s_out = 16'h8000; sat = 1'b1; end
    else                          s_out = 16'(c_fin);
  end

  // ---------------- reference model ----------------
  logic signed [15:0] va [64];
  logic signed [15:0] vb [64];

  function automatic logic [16:0] ref_dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(va[i]) * longint'(vb[i]);
      if (acc > MAX32) acc = MAX32;
      else if (acc < MIN32) acc = MIN32;
    end
    if (acc > 64'sd32767)  return {1'b1, 16'h7fff};
    if (acc < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, acc[15:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      2:       return 16'hffff;
      3:       return 16'(int'($urandom_range(0, 40)) - 20);
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   n_aen = 0, n_ben = 0, n_men = 0, n_sen = 0, n_sreset = 0;
  int   last_acc = -1, rv_rise = -1;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aen)    n_aen++;
    if (ben)    n_ben++;
    if (men)    n_men++;
    if (sen)    n_sen++;
    if (sreset) n_sreset++;
    if (in_valid && in_ready) last_acc = cyc;
    if (res_valid && !rv_prev) rv_rise = cyc;
    rv_prev = res_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_vec(input int n);
    start   = 1'b1;
    vec_len = LEN_W'(n);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // bubble_pct < 0 selects a strict 1,0,1,0 valid pattern
  task automatic feed(input int n, input int bubble_pct, input string tag);
    int k = 0;
    int g = 0;
    bit acc;
    while (k < n && g < 2000) begin
      if (bubble_pct < 0) in_valid = (g % 2 == 0);
      else                in_valid = (int'($urandom_range(0, 99)) >= bubble_pct);
      a_in = in_valid ? va[k] : 16'($urandom);
      b_in = in_valid ? vb[k] : 16'($urandom);
      acc  = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s_feed: accepted=%0d required=%0d", tag, k, n);
    end
  endtask

  task automatic wait_valid(input string tag);
    int g = 0;
    while (res_valid !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: res_valid=%b required=1 within 100 cycles", tag, res_valid);
    end
  endtask

  task automatic pop_result(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, aen, ben, men, sen, sreset, res_valid, res_sat, busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got=%b required=%b",
               {in_ready, aen, ben, men, sen, sreset, res_valid, res_sat, busy}, 9'b0);
    end
    checks++;
    if (res_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got=%h required=0000", res_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || a_value !== a_in || b_value !== b_in) begin
      errors++;
      $display("FAIL idle_pass: busy=%b res_valid=%b a_value=%h b_value=%h required 0 0 %h %h",
               busy, res_valid, a_value, b_value, a_in, b_in);
    end
  endtask

  task automatic run_fixed(input string tag, input int pattern);
    int b_aen = n_aen, b_ben = n_ben, b_men = n_men, b_sen = n_sen, b_sr = n_sreset;
    logic [16:0] exp;
    va[0] = 16'sd1; va[1] = 16'sd2; va[2] = 16'sd3;
    vb[0] = 16'sd4; vb[1] = 16'sd5; vb[2] = 16'sd6;
    exp = ref_dot(3);
    start_vec(3);
    feed(3, pattern, tag);
    wait_valid(tag);
    @(negedge clk); #1;
    checks++;
    if ({res_sat, res_data} !== exp || res_data !== 16'd32) begin
      errors++;
      $display("FAIL %s_result: got sat=%b data=%0d required sat=%b data=%0d",
               tag, res_sat, $signed(res_data), exp[16], $signed(exp[15:0]));
    end
    checks++;
    if (n_aen - b_aen != 3 || n_ben - b_ben != 3 || n_men - b_men != 3 ||
        n_sen - b_sen != 2 || n_sreset - b_sr != 1) begin
      errors++;
      $display("FAIL %s_pulses: aen=%0d ben=%0d men=%0d sen=%0d sreset=%0d required 3 3 3 2 1",
               tag, n_aen - b_aen, n_ben - b_ben, n_men - b_men, n_sen - b_sen, n_sreset - b_sr);
    end
    checks++;
    if (rv_rise - last_acc != 3) begin
      errors++;
      $display("FAIL %s_latency: got=%0d required=3", tag, rv_rise - last_acc);
    end
    pop_result(0);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pop: res_valid=%b busy=%b required 0 0", tag, res_valid, busy);
    end
  endtask

  task automatic test_basic();
    run_fixed("basic", 0);
  endtask

  task automatic test_bubbles();
    run_fixed("bubble", -1);
  endtask

  task automatic test_saturation();
    for (int v = 0; v < 2; v++) begin
      logic [16:0] exp;
      logic [16:0] want;
      for (int i = 0; i < 2; i++) begin
        va[i] = (v == 0) ? 16'sh7fff : 16'sh8000;
        vb[i] = (v == 0) ? 16'sh7fff : 16'sh0001;
      end
      want = (v == 0) ? {1'b1, 16'h7fff} : {1'b1, 16'h8000};
      exp  = ref_dot(2);
      start_vec(2);
      feed(2, 0, "sat");
      wait_valid("sat");
      checks++;
      if ({res_sat, res_data} !== exp || exp !== want) begin
        errors++;
        $display("FAIL sat_result%0d: got sat=%b data=%h required sat=%b data=%h",
                 v, res_sat, res_data, want[16], want[15:0]);
      end
      pop_result(1);
    end
  endtask

  task automatic test_zero_len();
    int b_aen = n_aen, b_men = n_men, b_sen = n_sen, b_sr = n_sreset;
    start_vec(0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: res_valid=%b data=%h sat=%b required 1 0000 0",
               res_valid, res_data, res_sat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_aen != b_aen || n_men != b_men || n_sen != b_sen || n_sreset != b_sr) begin
      errors++;
      $display("FAIL zero_pulses: aen=%0d men=%0d sen=%0d sreset=%0d required 0 0 0 0",
               n_aen - b_aen, n_men - b_men, n_sen - b_sen, n_sreset - b_sr);
    end
    pop_result(0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pop: res_valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_hold_backpressure();
    logic [16:0] exp1;
    logic [16:0] exp2;
`ifndef DSP_SEQ_RES_SKID_EN
    for (int i = 0; i < 3; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
    exp1 = ref_dot(3);
    start_vec(3);
    feed(3, 20, "bp1");
    wait_valid("bp1");
    start   = 1'b1;
    vec_len = LEN_W'(2);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || {res_sat, res_data} !== exp1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b sat=%b data=%h in_ready=%b busy=%b required 1 %b %h 0 1",
                 c, res_valid, res_sat, res_data, in_ready, busy, exp1[16], exp1[15:0]);
      end
    end
    for (int i = 0; i < 2; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
    exp2 = ref_dot(2);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop: res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_restart: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    feed(2, 0, "bp2");
    wait_valid("bp2");
    checks++;
    if ({res_sat, res_data} !== exp2) begin
      errors++;
      $display("FAIL bp2_result: got sat=%b data=%h required sat=%b data=%h",
               res_sat, res_data, exp2[16], exp2[15:0]);
    end
    pop_result(0);
`else
    int g = 0;
    for (int i = 0; i < 2; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
    exp1 = ref_dot(2);
    start   = 1'b1;
    vec_len = LEN_W'(2);
    @(posedge clk); #1;
    feed(2, 0, "bpA");
    for (int i = 0; i < 2; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
    exp2 = ref_dot(2);
    feed(2, 0, "bpB");
    while (busy !== 1'b0 && g < 50) begin @(posedge clk); #1; g++; end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || {res_sat, res_data} !== exp1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_full%0d: valid=%b sat=%b data=%h busy=%b in_ready=%b required 1 %b %h 0 0",
                 c, res_valid, res_sat, res_data, busy, in_ready, exp1[16], exp1[15:0]);
      end
    end
    start = 1'b0;
    pop_result(0);
    checks++;
    if (res_valid !== 1'b1 || {res_sat, res_data} !== exp2) begin
      errors++;
      $display("FAIL bp_second: valid=%b sat=%b data=%h required 1 %b %h",
               res_valid, res_sat, res_data, exp2[16], exp2[15:0]);
    end
    pop_result(0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: res_valid=%b required 0", res_valid);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [16:0] exp;
    for (int i = 0; i < 4; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
    start_vec(4);
    feed(2, 0, "rmr");
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, aen, ben, men, sen, sreset, res_valid, res_sat, busy} !== 9'b0 || res_data !== 16'h0000) begin
      errors++;
      $display("FAIL rmr_outputs: ctrl=%b data=%h required %b 0000",
               {in_ready, aen, ben, men, sen, sreset, res_valid, res_sat, busy}, res_data, 9'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    va[0] = 16'sd5;
    vb[0] = -16'sd3;
    exp = ref_dot(1);
    start_vec(1);
    feed(1, 0, "rmr1");
    wait_valid("rmr1");
    checks++;
    if ({res_sat, res_data} !== exp || res_data !== 16'hfff1) begin
      errors++;
      $display("FAIL rmr_result: got sat=%b data=%0d required sat=0 data=-15",
               res_sat, $signed(res_data));
    end
    pop_result(0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int n;
      int b_aen;
      int b_sr;
      logic [16:0] exp;
      n = (it % 10 == 9) ? int'($urandom_range(9, 20)) : int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) begin va[i] = rand_op(); vb[i] = rand_op(); end
      exp   = ref_dot(n);
      b_aen = n_aen;
      b_sr  = n_sreset;
      start_vec(n);
      if (n > 0) feed(n, int'($urandom_range(0, 60)), "rand");
      wait_valid("rand");
      repeat (int'($urandom_range(0, 3))) begin @(posedge clk); #1; end
      checks++;
      if ({res_sat, res_data} !== exp) begin
        errors++;
        $display("FAIL rand%0d_result: n=%0d got sat=%b data=%h required sat=%b data=%h",
                 it, n, res_sat, res_data, exp[16], exp[15:0]);
      end
      checks++;
      if (n_aen - b_aen != n || n_sreset - b_sr != ((n > 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d_pulses: aen=%0d sreset=%0d required %0d %0d",
                 it, n_aen - b_aen, n_sreset - b_sr, n, (n > 0) ? 1 : 0);
      end
      pop_result(0);
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_pop: res_valid=%b required 0", it, res_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_saturation();
    test_zero_len();
    test_hold_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_seq.md
Name: dsp_seq

Overview:
- Sequencer and result reader for one systolic DSP MAC cell.
- Accepts a start command with a vector length, then streams operand pairs into the cell. It drives the cell's a/b/m/s stage enables and closes the dot product with a sreset pulse.
- Returns the cell's 16-bit saturated sum and sat flag over a valid/ready result port.
- Sits between the array feeder/drain logic and each dsp cell.

Parameters:
LEN_W, 8, width of the vector-length field and the beat counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  start command, sampled only in IDLE
vec_len  in  LEN_W  number of products in the vector, latched on start
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid & in_ready
a_in  in  16  signed operand A
b_in  in  16  signed operand B
a_value  out  16  to the cell; equals a_in (combinational)
b_value  out  16  to the cell; equals b_in (combinational)
aen  out  1  cell A-register enable
ben  out  1  cell B-register enable
men  out  1  cell multiplier-register enable
sen  out  1  cell accumulate enable
sreset  out  1  cell final-add/capture/clear pulse
sat  in  1  saturation flag from the cell
s_out  in  16  signed result from the cell
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_data  out  16  signed dot-product result
res_sat  out  1  result saturated
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst=1): state IDLE. in_ready, aen, ben, men, sen, sreset, res_valid, res_sat, busy are 0. res_data is 0. Counters and pipeline flags are cleared.
- The integrator ties the cell reset to ~rst, so reset mid-operation also clears the cell accumulator.
- States: IDLE, RUN, DRAIN, HOLD.
  - IDLE: start=1 and vec_len!=0 -> latch len, clear beat count, go to RUN.
  - IDLE: start=1 and vec_len=0 -> go to HOLD with res_data=0, res_sat=0. No cell enables pulse.
  - IDLE: start while not IDLE is ignored.
- RUN:
  - in_ready=1. accept = in_valid & in_ready. aen = ben = accept.
  - Beat counter increments per accept.
  - Accept with count==len-1 marks the beat last and moves to DRAIN.
  - in_valid=0 inserts bubbles; no enable pulses for bubble cycles.
- Pipeline flags:
  - v1 <= accept, l1 <= accept & last; v2 <= v1, l2 <= l1.
  - men = v1.
  - sen = v2 & ~l2.
  - sreset = v2 & l2, i.e. the final beat's accumulate is replaced by sreset. The cell adds the last product, drives s_out/sat, and clears its accumulator.
- DRAIN: in_ready=0. The cycle after sreset -> HOLD, capturing s_out/sat into res_data/res_sat.
- Latency: last accept at cycle t -> men t+1, sreset t+2, res_valid high from t+3.
- HOLD: res_valid=1. res_data/res_sat are stable until the handshake. res_valid & res_ready -> IDLE.
- Back-to-back vectors: a new start is accepted in IDLE only. The minimum gap from result handshake to the next start is 1 cycle.
- res_sat reflects saturation of the final add only; intermediate accumulate saturation is not visible to the sequencer.
- Cell arithmetic (done by the cell, not here): 16x16 signed products; 32-bit signed accumulator clamped at 0x7fffffff/0x80000000; 16-bit output clamped to 0x7fff/0x8000 with sat=1.

Optional Feature:
- DSP_SEQ_RES_SKID_EN defined:
  - Results go into a 2-entry result FIFO and the FSM returns from DRAIN straight to IDLE.
  - res_valid = FIFO not empty; res_data/res_sat = FIFO head.
  - start is accepted only while FIFO occupancy plus in-flight results is <2.
  - A vec_len=0 start pushes the entry {0,0}.
- Undefined: HOLD state as described above; no FIFO storage.

Test Plan:
- vec_len=3, a={1,2,3}, b={4,5,6}, in_valid held high -> aen for 3 cycles, sen pulses 2, sreset 1; res_data=32, res_sat=0; res_valid 3 cycles after the last accept.
- Same vector with in_valid toggling 1,0,1,0,1 -> exactly 3 aen pulses, no stray men/sen; res_data=32.
- vec_len=2, a=b=0x7fff twice -> res_data=0x7fff, res_sat=1. vec_len=2, a=0x8000, b=1 twice -> res_data=0x8000, res_sat=1.
- vec_len=0 -> res_valid the cycle after start, res_data=0, res_sat=0; aen/men/sen/sreset never pulse.
- res_ready low 6 cycles with start held high:
  - Without the macro: no second vector accepted and res_data stable.
  - With the macro: two results queue, start blocked until a pop, FIFO order preserved.
- rst=1 asserted during RUN after 2 of 4 beats -> all outputs 0, state IDLE. Next vec_len=1, a=5, b=-3 -> res_data=-15, res_sat=0.
